// File: rtl/mem_copy.sv
// mem_copy: single-channel word copy engine.
// Reads one 32-bit word from the source pointer, writes it to the destination
// pointer, advances both by 4 bytes and repeats until the word count is used
// up. At most one bus transaction is in flight at any time.
// Optional build macro MEM_COPY_ABORT_EN adds an abort_i input that ends the
// copy after the word whose write response is being taken.
`timescale 1ns/1ps

module mem_copy #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
`ifdef MEM_COPY_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      addr_o,
    output logic [31:0]      data_o,
    output logic [3:0]       sel_o,
    output logic             we_o,
    input  logic [31:0]      data_i,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    input  logic             rsp_valid_i,
    output logic             rsp_ready_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_REQ = 3'd1;
    localparam logic [2:0] RD_RSP = 3'd2;
    localparam logic [2:0] WR_REQ = 3'd3;
    localparam logic [2:0] WR_RSP = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [29:0]      src_ptr;     // word pointers: byte address bits [31:2]
    logic [29:0]      dst_ptr;
    logic [LEN_W-1:0] count;
    logic [31:0]      word_buf;
    logic             req_fire;
    logic             rsp_fire;
    logic             abort_now;
    logic             last_word;

    // Byte-offset bits of the start addresses are dropped on purpose.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{src_addr_i[1:0], dst_addr_i[1:0]};

    assign req_fire  = req_valid_o && req_ready_i;
    assign rsp_fire  = rsp_valid_i && rsp_ready_o;
    assign last_word = (count == LEN_W'(1)) || abort_now;
    assign sel_o     = 4'b1111;

`ifdef MEM_COPY_ABORT_EN
    logic abort_pend;

    assign abort_now = abort_i || abort_pend;

    // Remember an abort seen mid-copy until the next write response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_pend <= 1'b0;
        end else if (state == IDLE || state == DONE) begin
            abort_pend <= 1'b0;
        end else if (state == WR_RSP && rsp_fire) begin
            abort_pend <= 1'b0;
        end else if (abort_i) begin
            abort_pend <= 1'b1;
        end
    end
`else
    assign abort_now = 1'b0;
`endif

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one outstanding transaction, read then write per word.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (len_i == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: if (req_fire) state_nxt = RD_RSP;
            RD_RSP: if (rsp_fire) state_nxt = WR_REQ;
            WR_REQ: if (req_fire) state_nxt = WR_RSP;
            WR_RSP: begin
                if (rsp_fire) begin
                    state_nxt = last_word ? DONE : RD_REQ;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pointers, remaining count and the word buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            word_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_ptr <= src_addr_i[31:2];
                        dst_ptr <= dst_addr_i[31:2];
                        count   <= len_i;
                    end
                end
                RD_RSP: begin
                    if (rsp_fire) begin
                        word_buf <= data_i;
                    end
                end
                WR_RSP: begin
                    if (rsp_fire) begin
                        // 30-bit word pointers wrap modulo 2^32 bytes for free.
                        count   <= count - LEN_W'(1);
                        src_ptr <= src_ptr + 30'd1;
                        dst_ptr <= dst_ptr + 30'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the state; requests stay stable while pending.
    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        addr_o      = '0;
        data_o      = '0;
        we_o        = 1'b0;
        req_valid_o = 1'b0;
        rsp_ready_o = 1'b0;
        case (state)
            RD_REQ: begin
                busy_o      = 1'b1;
                req_valid_o = 1'b1;
                addr_o      = {src_ptr, 2'b00};
            end
            RD_RSP: begin
                busy_o      = 1'b1;
                rsp_ready_o = 1'b1;
            end
            WR_REQ: begin
                busy_o      = 1'b1;
                req_valid_o = 1'b1;
                we_o        = 1'b1;
                addr_o      = {dst_ptr, 2'b00};
                data_o      = word_buf;
            end
            WR_RSP: begin
                busy_o      = 1'b1;
                rsp_ready_o = 1'b1;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy.sv
// tb_mem_copy: self-checking bench for mem_copy.
// A bus responder with random stalls serves reads from a source-memory model
// and logs every transferred request; each copy is then compared with the
// expected sequence of word reads and writes computed from the copy request.
`timescale 1ns/1ps

module tb_mem_copy;

    localparam int LEN_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [31:0]      src_addr_i;
    logic [31:0]      dst_addr_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic             done_o;
    logic [31:0]      addr_o;
    logic [31:0]      data_o;
    logic [3:0]       sel_o;
    logic             we_o;
    logic [31:0]      data_i;
    logic             req_valid_o;
    logic             req_ready_i;
    logic             rsp_valid_i;
    logic             rsp_ready_o;
`ifdef MEM_COPY_ABORT_EN
    logic             abort_i;
`endif

    int n_tests;
    int n_fail;

    logic [31:0] mem [logic [31:0]];   // preloaded source words
    logic [31:0] rd_log [$];           // read addresses as transferred
    logic [63:0] wr_log [$];           // {addr, data} of writes as transferred
    bit          zero_wait;
    int          stall_cnt;
    logic [31:0] exp_src;
    logic [31:0] exp_dst;
    int          exp_len;

    mem_copy #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .len_i       (len_i),
`ifdef MEM_COPY_ABORT_EN
        .abort_i     (abort_i),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .sel_o       (sel_o),
        .we_o        (we_o),
        .data_i      (data_i),
        .req_valid_o (req_valid_o),
        .req_ready_i (req_ready_i),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Source memory content: preloaded words, else a fixed function of the address.
    function automatic logic [31:0] src_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'hC0DE, a[31:16]};
    endfunction

    // Bus responder: acts at each falling edge for the following rising edge.
    task automatic responder();
        bit          outst;
        bit          out_we;
        logic [31:0] out_addr;
        int          rsp_wait;
        bit          hold_prev;
        bit          hp_we;
        logic [31:0] hp_addr;
        logic [31:0] hp_data;
        outst     = 0;
        hold_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_ready_i = 1'b0;
                rsp_valid_i = 1'b0;
                data_i      = '0;
                outst       = 0;
                hold_prev   = 0;
            end else begin
                if (hold_prev) begin
                    check("req hold ctl", {req_valid_o, we_o}, {1'b1, hp_we});
                    check("req hold addr", addr_o, hp_addr);
                    check("req hold data", data_o, hp_data);
                end
                rsp_valid_i = 1'b0;
                data_i      = $urandom;
                if (outst) begin
                    if (rsp_wait == 0) begin
                        rsp_valid_i = 1'b1;
                        if (!out_we) data_i = src_word(out_addr);
                    end else begin
                        rsp_wait--;
                    end
                end
                if (rsp_valid_i && rsp_ready_o) outst = 0;
                if (stall_cnt > 0 && req_valid_o) begin
                    req_ready_i = 1'b0;
                    stall_cnt--;
                end else begin
                    req_ready_i = zero_wait ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                end
                if (req_valid_o && req_ready_i) begin
                    check("one outstanding", 64'(outst), 64'd0);
                    outst    = 1;
                    out_we   = we_o;
                    out_addr = addr_o;
                    rsp_wait = zero_wait ? 0 : int'($urandom_range(0, 2));
                    if (we_o) wr_log.push_back({addr_o, data_o});
                    else      rd_log.push_back(addr_o);
                end
                hold_prev = req_valid_o && !req_ready_i;
                hp_we     = we_o;
                hp_addr   = addr_o;
                hp_data   = data_o;
            end
        end
    endtask

    // Issue a start pulse; returns at the falling edge of the following cycle.
    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                              input int len, input string tag);
        rd_log.delete();
        wr_log.delete();
        exp_src = {src[31:2], 2'b00};
        exp_dst = {dst[31:2], 2'b00};
        exp_len = len;
        @(negedge clk);
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = LEN_W'(len);
        start_i    = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        src_addr_i = $urandom;
        dst_addr_i = $urandom;
        len_i      = LEN_W'($urandom);
        // Zero length: done right away. Otherwise: busy with the first read request.
        check({tag, " first cycle"}, {busy_o, done_o, req_valid_o, we_o},
              (len == 0) ? 4'b0100 : 4'b1010);
    endtask

    // Wait for done_o, then compare the logged traffic with the expected copy.
    task automatic finish_copy(input string tag, input int abort_at);
        int          cyc;
        int          n_exp;
        bit          ab_sent;
        logic [31:0] a;
        n_exp   = (abort_at > 0 && abort_at < exp_len) ? abort_at : exp_len;
        cyc     = 0;
        ab_sent = 0;
        while (done_o !== 1'b1 && cyc < 400) begin
            check({tag, " busy"}, 64'(busy_o), 64'd1);
            start_i = 1'($urandom_range(0, 1));   // must be ignored while busy
            len_i   = LEN_W'($urandom_range(0, 3));
`ifdef MEM_COPY_ABORT_EN
            abort_i = 1'b0;
            if (abort_at > 0 && !ab_sent && rd_log.size() == abort_at) begin
                abort_i = 1'b1;
                ab_sent = 1;
            end
`endif
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
`ifdef MEM_COPY_ABORT_EN
        abort_i = 1'b0;
`endif
        check({tag, " done"}, {done_o, busy_o, req_valid_o, rsp_ready_o}, 4'b1000);
        check({tag, " sel"}, sel_o, 4'hF);
        @(negedge clk);
        check({tag, " idle"}, {done_o, busy_o, req_valid_o, rsp_ready_o, we_o}, 5'b0);
        check({tag, " n reads"}, rd_log.size(), n_exp);
        check({tag, " n writes"}, wr_log.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            a = exp_src + 32'(4 * i);
            check({tag, " rd addr"}, (i < rd_log.size()) ? rd_log[i] : 32'hx, a);
            check({tag, " wr"}, (i < wr_log.size()) ? wr_log[i] : 64'hx,
                  {exp_dst + 32'(4 * i), src_word(a)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_done;
        n_tests     = 0;
        n_fail      = 0;
        zero_wait   = 0;
        stall_cnt   = 0;
        start_i     = 1'b0;
        src_addr_i  = '0;
        dst_addr_i  = '0;
        len_i       = '0;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        data_i      = '0;
`ifdef MEM_COPY_ABORT_EN
        abort_i     = 1'b0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset ctl", {req_valid_o, rsp_ready_o, we_o, busy_o, done_o}, 5'b0);
        check("reset addr", addr_o, 32'h0);
        check("reset data", data_o, 32'h0);
        fork
            responder();
        join_none
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Three words through a zero-wait responder.
        mem[32'h100] = 32'hA0;
        mem[32'h104] = 32'hA1;
        mem[32'h108] = 32'hA2;
        zero_wait = 1;
        start_copy(32'h100, 32'h200, 3, "basic");
        finish_copy("basic", 0);
        check("basic wr0", (wr_log.size() > 0) ? wr_log[0] : 64'hx, {32'h200, 32'hA0});
        check("basic wr1", (wr_log.size() > 1) ? wr_log[1] : 64'hx, {32'h204, 32'hA1});
        check("basic wr2", (wr_log.size() > 2) ? wr_log[2] : 64'hx, {32'h208, 32'hA2});
        zero_wait = 0;

        // Zero length: no bus traffic, done_o in the cycle after start_i is sampled.
        start_copy(32'h300, 32'h400, 0, "len0");
        finish_copy("len0", 0);

        // First request held off for five cycles must not change.
        stall_cnt = 5;
        start_copy(32'h1003, 32'h2001, 2, "stall");
        for (int i = 0; i < 5; i++) begin
            check("stall hold", {req_valid_o, we_o, addr_o}, {1'b1, 1'b0, 32'h1000});
            @(negedge clk);
        end
        finish_copy("stall", 0);

        // Source pointer wraps past the top of the address space.
        start_copy(32'hFFFF_FFFC, 32'h10, 2, "wrap");
        finish_copy("wrap", 0);
        check("wrap 2nd read", (rd_log.size() > 1) ? rd_log[1] : 32'hx, 32'h0);

        // Randomised copies.
        for (int t = 0; t < 12; t++) begin
            start_copy($urandom, $urandom, int'($urandom_range(1, 6)), "rand");
            finish_copy("rand", 0);
        end

        // Reset in the middle of a write request abandons the copy.
        start_copy(32'h4000, 32'h8000, 4, "rst");
        cyc = 0;
        while (!(req_valid_o && we_o) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst reached wr_req", {req_valid_o, we_o}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst mid ctl", {req_valid_o, rsp_ready_o, we_o, busy_o, done_o}, 5'b0);
        check("rst mid addr", addr_o, 32'h0);
        check("rst mid data", data_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o) n_done++;
        end
        check("rst no done", n_done, 0);
        check("rst idle", {busy_o, req_valid_o}, 2'b00);

        // Engine is usable again after the abandoned copy.
        start_copy(32'h7000, 32'h9000, 3, "after rst");
        finish_copy("after rst", 0);

`ifdef MEM_COPY_ABORT_EN
        // Abort during the second read: two words written, then done.
        start_copy(32'h500, 32'h600, 8, "abort");
        finish_copy("abort", 2);
        start_copy(32'h520, 32'h620, 3, "post abort");
        finish_copy("post abort", 0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
